path_backtracker: RTL and testbench

//  Reader side of the search engine's discard memories. After a search finishes, it walks

---
 rtl/path_backtracker.sv | 159 +++++++++++++++
 tb/tb_path_backtracker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_backtracker.sv
// path_backtracker: walks the discard memories from dst back to src after a
// search completes, streaming the path (dst first, src last) with per-hop cost,
// accumulating total cost (saturating) and hop count. Read-only on the memories.
module path_backtracker #(
  parameter int VW      = 16,
  parameter int AW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [VW-1:0] src_vertex,
  input  logic [VW-1:0] dst_vertex,
  input  logic [AW-1:0] discard_count,
  output logic [AW-1:0] discard_addr,
  input  logic [VW-1:0] vertex_discard_q,
  input  logic [VW-1:0] prev_discard_q,
  input  logic [VW-1:0] dist_discard_q,
  output logic          path_valid,
  input  logic          path_ready,
  output logic [VW-1:0] path_vertex,
  output logic [VW-1:0] path_dist,
  output logic          path_last,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [VW-1:0] total_dist,
  output logic [AW-1:0] hop_count
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CMP, EMIT, EMIT_SRC, FAIL, DONE
  } state_t;

  // WAIT covers MEM_LAT-1 cycles; the counter runs 0..MEM_LAT-2 inside it.
  localparam logic [7:0]    WAIT_LAST = 8'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  state_t        state, state_nxt;
  logic [VW-1:0] src_r, cur, prev_r, dist_r;
  logic [AW-1:0] idx, idx_nxt;
  logic [7:0]    wcnt;
  logic          start_acc, hit;

  // Unsigned add clamped to all-ones on carry out.
  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a,
                                            input logic [VW-1:0] b);
    logic [VW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VW] ? {VW{1'b1}} : s[VW-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, probe index and stream/status outputs decoded from state.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    start_acc   = 1'b0;
    hit         = (vertex_discard_q == cur);
    path_valid  = 1'b0;
    path_vertex = '0;
    path_dist   = '0;
    path_last   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE, DONE: begin
        busy      = 1'b0;
        done      = (state == DONE);
        state_nxt = IDLE;
        if (start) begin
          start_acc = 1'b1;
          idx_nxt   = discard_count - ONE_A;
          if (dst_vertex == src_vertex)   state_nxt = EMIT_SRC;
          else if (discard_count == '0)   state_nxt = FAIL;
          else                            state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = (MEM_LAT > 1) ? WAIT : CMP;
      WAIT: begin
        if (wcnt == WAIT_LAST) state_nxt = CMP;
      end
      CMP: begin
        if (hit)              state_nxt = EMIT;
        else if (idx == '0)   state_nxt = FAIL;
        else begin
          idx_nxt   = idx - ONE_A;
          state_nxt = ISSUE;
        end
      end
      EMIT: begin
        path_valid  = 1'b1;
        path_vertex = cur;
        path_dist   = dist_r;
        if (path_ready) begin
          if (prev_r == src_r)  state_nxt = EMIT_SRC;
          else if (idx == '0)   state_nxt = FAIL;
          else begin
            idx_nxt   = idx - ONE_A;
            state_nxt = ISSUE;
          end
        end
      end
      EMIT_SRC: begin
        path_valid  = 1'b1;
        path_vertex = src_r;
        path_last   = 1'b1;
        if (path_ready) state_nxt = DONE;
      end
      FAIL:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trace datapath: probe address, current vertex, latched entry, totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard_addr <= '0;
      idx          <= '0;
      wcnt         <= '0;
      src_r        <= '0;
      cur          <= '0;
      prev_r       <= '0;
      dist_r       <= '0;
      found        <= 1'b0;
      total_dist   <= '0;
      hop_count    <= '0;
    end else begin
      idx <= idx_nxt;
      if (state_nxt == ISSUE) discard_addr <= idx_nxt;
      if (state == ISSUE)     wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + 8'd1;
      if (start_acc) begin
        src_r      <= src_vertex;
        cur        <= dst_vertex;
        found      <= 1'b0;
        total_dist <= '0;
        hop_count  <= '0;
      end
      if (state == CMP && hit) begin
        prev_r <= prev_discard_q;
        dist_r <= dist_discard_q;
      end
      if (state == EMIT && path_ready) begin
        total_dist <= sat_add(total_dist, dist_r);
        hop_count  <= hop_count + ONE_A;
        cur        <= prev_r;
      end
      if (state == EMIT_SRC && path_ready) found <= 1'b1;
      if (state == FAIL)                   found <= 1'b0;
    end
  end

endmodule

// File: tb/tb_path_backtracker.sv
// Directed bench for path_backtracker with a 2-cycle-latency discard memory model.
module tb_path_backtracker;
  localparam int VW = 16;
  localparam int AW = 16;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst, start, path_ready;
  logic [VW-1:0] src_vertex, dst_vertex;
  logic [AW-1:0] discard_count, discard_addr;
  logic [VW-1:0] vertex_discard_q, prev_discard_q, dist_discard_q;
  logic          path_valid, path_last, busy, done, found;
  logic [VW-1:0] path_vertex, path_dist, total_dist;
  logic [AW-1:0] hop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  path_backtracker #(.VW(VW), .AW(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_vertex(src_vertex), .dst_vertex(dst_vertex), .discard_count(discard_count),
    .discard_addr(discard_addr), .vertex_discard_q(vertex_discard_q),
    .prev_discard_q(prev_discard_q), .dist_discard_q(dist_discard_q),
    .path_valid(path_valid), .path_ready(path_ready), .path_vertex(path_vertex),
    .path_dist(path_dist), .path_last(path_last), .busy(busy), .done(done),
    .found(found), .total_dist(total_dist), .hop_count(hop_count)
  );

  always #5 clk = ~clk;

  // Discard memory model: q reflects the address presented ML cycles earlier.
  logic [VW-1:0] mv [4];
  logic [VW-1:0] mp [4];
  logic [VW-1:0] md [4];
  logic [AW-1:0] a1, a2;
  always @(posedge clk) begin
    a1 <= discard_addr;
    a2 <= a1;
    cyc <= cyc + 1;
  end
  assign vertex_discard_q = (a2 < 4) ? mv[a2[1:0]] : '0;
  assign prev_discard_q   = (a2 < 4) ? mp[a2[1:0]] : '0;
  assign dist_discard_q   = (a2 < 4) ? md[a2[1:0]] : '0;

  // Monitor: accepted words and probe address changes while busy, with cycle stamps.
  logic [2*VW:0] wq[$];
  int            wcyc[$];
  logic [AW-1:0] addrq[$];
  int            acyc[$];
  logic [AW-1:0] last_addr;
  always @(negedge clk) begin
    if (path_valid && path_ready) begin
      wq.push_back({path_vertex, path_dist, path_last});
      wcyc.push_back(cyc);
    end
    if (busy && discard_addr !== last_addr) begin
      addrq.push_back(discard_addr);
      acyc.push_back(cyc);
    end
    last_addr = discard_addr;
  end

  task automatic mem_default();
    mv[0] = 3; mp[0] = 3; md[0] = 0;
    mv[1] = 5; mp[1] = 3; md[1] = 4;
    mv[2] = 9; mp[2] = 3; md[2] = 7;
    mv[3] = 7; mp[3] = 5; md[3] = 2;
  endtask

  task automatic do_start(input logic [VW-1:0] s, input logic [VW-1:0] d,
                          input logic [AW-1:0] c);
    @(posedge clk); #1;
    src_vertex = s; dst_vertex = d; discard_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout: done never pulsed"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; path_ready = 1'b1;
    src_vertex = '0; dst_vertex = '0; discard_count = '0;
    mem_default();
    repeat (3) @(negedge clk);
    checks++;
    if ({path_valid, busy, done, found, path_last} !== 5'b0 || discard_addr !== '0 ||
        total_dist !== '0 || hop_count !== '0 || path_vertex !== '0 || path_dist !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b found=%b addr=%0d total=%0d hops=%0d, want all 0",
               path_valid, busy, done, found, discard_addr, total_dist, hop_count);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic_path(input string nm);
    logic [2*VW:0] exp [3];
    logic [AW-1:0] ea [3];
    int wm, am;
    bit ok;
    exp = '{{16'd7, 16'd2, 1'b0}, {16'd5, 16'd4, 1'b0}, {16'd3, 16'd0, 1'b1}};
    ea  = '{16'd3, 16'd2, 16'd1};
    wm = wq.size(); am = addrq.size();
    do_start(3, 7, 4);
    wait_done(ok);
    checks++;
    if (wq.size() - wm != 3) begin
      errors++; $display("FAIL %s_words: got %0d words, want 3", nm, wq.size() - wm);
    end
    for (int i = 0; i < 3 && wm + i < wq.size(); i++) begin
      checks++;
      if (wq[wm+i] !== exp[i]) begin
        errors++; $display("FAIL %s_word%0d: got %h, want %h", nm, i, wq[wm+i], exp[i]);
      end
    end
    checks++;
    if (addrq.size() - am != 3) begin
      errors++; $display("FAIL %s_probes: got %0d addr changes, want 3", nm, addrq.size() - am);
    end
    for (int i = 0; i < 3 && am + i < addrq.size(); i++) begin
      checks++;
      if (addrq[am+i] !== ea[i]) begin
        errors++; $display("FAIL %s_addr%0d: got %0d, want %0d", nm, i, addrq[am+i], ea[i]);
      end
    end
    if (wcyc.size() > wm && acyc.size() > am) begin
      checks++;
      if (wcyc[wm] - acyc[am] != 3) begin
        errors++; $display("FAIL %s_latency: first word %0d cycles after addr, want 3", nm, wcyc[wm] - acyc[am]);
      end
    end
    checks++;
    if (found !== 1'b1 || total_dist !== 16'd6 || hop_count !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_totals: found=%b total=%0d hops=%0d busy=%b, want 1 6 2 0",
               nm, found, total_dist, hop_count, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || found !== 1'b1 || total_dist !== 16'd6) begin
      errors++; $display("FAIL %s_hold: done=%b found=%b total=%0d, want 0 1 6", nm, done, found, total_dist);
    end
  endtask

  task automatic test_src_eq_dst();
    int wm, am;
    bit ok;
    wm = wq.size(); am = addrq.size();
    do_start(3, 3, 4);
    wait_done(ok);
    checks++;
    if (wq.size() - wm != 1 || (wq.size() > wm && wq[wm] !== {16'd3, 16'd0, 1'b1})) begin
      errors++; $display("FAIL same_word: got %0d words (first %h), want 1 word 00030000 last", wq.size() - wm,
                         (wq.size() > wm) ? wq[wm] : '0);
    end
    checks++;
    if (addrq.size() != am) begin
      errors++; $display("FAIL same_noaddr: got %0d addr changes, want 0", addrq.size() - am);
    end
    checks++;
    if (found !== 1'b1 || total_dist !== '0 || hop_count !== '0) begin
      errors++; $display("FAIL same_totals: found=%b total=%0d hops=%0d, want 1 0 0", found, total_dist, hop_count);
    end
  endtask

  task automatic test_not_found();
    logic [AW-1:0] ea [4];
    int wm, am;
    bit ok;
    ea = '{16'd3, 16'd2, 16'd1, 16'd0};
    wm = wq.size(); am = addrq.size();
    do_start(3, 8, 4);
    wait_done(ok);
    checks++;
    if (wq.size() != wm) begin
      errors++; $display("FAIL nf_words: got %0d words, want 0", wq.size() - wm);
    end
    checks++;
    if (addrq.size() - am != 4) begin
      errors++; $display("FAIL nf_probes: got %0d addr changes, want 4", addrq.size() - am);
    end
    for (int i = 0; i < 4 && am + i < addrq.size(); i++) begin
      checks++;
      if (addrq[am+i] !== ea[i]) begin
        errors++; $display("FAIL nf_addr%0d: got %0d, want %0d", i, addrq[am+i], ea[i]);
      end
    end
    checks++;
    if (found !== 1'b0 || hop_count !== '0 || total_dist !== '0) begin
      errors++; $display("FAIL nf_totals: found=%b total=%0d hops=%0d, want 0 0 0", found, total_dist, hop_count);
    end
  endtask

  task automatic test_backpressure();
    int wm;
    bit ok, seen;
    wm = wq.size();
    do_start(3, 7, 4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (path_valid && path_vertex == 16'd7) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1 path_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (path_valid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_second_word: path_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (path_valid !== 1'b1 || path_vertex !== 16'd5 || path_dist !== 16'd4 || path_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b vertex=%0d dist=%0d last=%b, want 1 5 4 0",
                 i, path_valid, path_vertex, path_dist, path_last);
      end
      @(negedge clk);
    end
    @(posedge clk); #1 path_ready = 1'b1;
    wait_done(ok);
    checks++;
    if (wq.size() - wm != 3 || (wq.size() - wm == 3 && wq[wm+1] !== {16'd5, 16'd4, 1'b0})) begin
      errors++; $display("FAIL bp_words: got %0d words, want 3 with (5,4) once", wq.size() - wm);
    end
    checks++;
    if (found !== 1'b1 || total_dist !== 16'd6 || hop_count !== 16'd2) begin
      errors++; $display("FAIL bp_totals: found=%b total=%0d hops=%0d, want 1 6 2", found, total_dist, hop_count);
    end
  endtask

  // Entry 1 points back to an absent vertex 12: two words go out, then the scan dies at idx 0.
  task automatic test_broken_chain();
    int wm;
    bit ok;
    mp[1] = 12;
    wm = wq.size();
    do_start(3, 7, 4);
    wait_done(ok);
    checks++;
    if (wq.size() - wm != 2 || (wq.size() - wm == 2 &&
        (wq[wm] !== {16'd7, 16'd2, 1'b0} || wq[wm+1] !== {16'd5, 16'd4, 1'b0}))) begin
      errors++; $display("FAIL broken_words: got %0d words, want (7,2)(5,4)", wq.size() - wm);
    end
    checks++;
    if (found !== 1'b0 || hop_count !== 16'd2 || total_dist !== 16'd6) begin
      errors++; $display("FAIL broken_totals: found=%b total=%0d hops=%0d, want 0 6 2", found, total_dist, hop_count);
    end
    mem_default();
  endtask

  // Vertex 5 missing from the discard list: only (7,2) goes out before the scan fails.
  task automatic test_missing_pred();
    int wm;
    bit ok;
    mv[1] = 12;
    wm = wq.size();
    do_start(3, 7, 4);
    wait_done(ok);
    checks++;
    if (wq.size() - wm != 1 || (wq.size() > wm && wq[wm] !== {16'd7, 16'd2, 1'b0})) begin
      errors++; $display("FAIL missing_words: got %0d words, want only (7,2)", wq.size() - wm);
    end
    checks++;
    if (found !== 1'b0 || hop_count !== 16'd1 || total_dist !== 16'd2) begin
      errors++; $display("FAIL missing_totals: found=%b total=%0d hops=%0d, want 0 2 1", found, total_dist, hop_count);
    end
    mem_default();
  endtask

  task automatic test_saturate();
    bit ok;
    md[3] = 16'hFFF0; md[1] = 16'h0020;
    do_start(3, 7, 4);
    wait_done(ok);
    checks++;
    if (total_dist !== 16'hFFFF || hop_count !== 16'd2 || found !== 1'b1) begin
      errors++; $display("FAIL sat_total: total=%h hops=%0d found=%b, want ffff 2 1", total_dist, hop_count, found);
    end
    mem_default();
  endtask

  task automatic test_reset_mid_trace();
    int wm;
    wm = wq.size();
    do_start(3, 7, 4);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++;
    if ({path_valid, busy, done, found} !== 4'b0 || discard_addr !== '0 ||
        total_dist !== '0 || hop_count !== '0) begin
      errors++;
      $display("FAIL midrst_state: valid=%b busy=%b done=%b found=%b addr=%0d total=%0d hops=%0d, want all 0",
               path_valid, busy, done, found, discard_addr, total_dist, hop_count);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wq.size() != wm) begin
      errors++; $display("FAIL midrst_quiet: done=%b busy=%b words=%0d, want 0 0 0", done, busy, wq.size() - wm);
    end
    test_basic_path("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic_path("basic");
    test_src_eq_dst();
    test_not_found();
    test_backpressure();
    test_broken_chain();
    test_missing_pred();
    test_saturate();
    test_reset_mid_trace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
